wb_reg_file: RTL and testbench
==============================

WB_REG_FILE -- requirements
Module: wb_reg_file

Interface
REQ-001 Parameters SHALL be: DATA_W, 32, register data width; ADDR_W, 5, register address width; NREGS, 32, number of architectural registers.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 wb_control_in  input  2  writeback control from the MEM/WB register; bit1 = RegWrite, bit0 = MemtoReg.
REQ-005 wb_read_data  input  DATA_W  data-memory load value from MEM/WB.
REQ-006 wb_alu_result  input  DATA_W  ALU result from MEM/WB.
REQ-007 wb_write_reg  input  ADDR_W  destination register index from MEM/WB.
REQ-008 rs_addr  input  ADDR_W  read port A index (ID stage).
REQ-009 rt_addr  input  ADDR_W  read port B index (ID stage).
REQ-010 rs_data  output  DATA_W  read port A data, combinational.
REQ-011 rt_data  output  DATA_W  read port B data, combinational.
REQ-012 wb_write_data  output  DATA_W  selected writeback value, combinational.
REQ-013 wb_count  output  32  registered count of committed register writes.

Function
REQ-014 wb_write_data SHALL equal wb_read_data when MemtoReg=1, else wb_alu_result.
REQ-015 A commit SHALL occur at a rising clk edge when rst=0, RegWrite=1 and wb_write_reg!=0; regs[wb_write_reg] takes wb_write_data at that edge.
REQ-016 Writes with wb_write_reg=0 SHALL be discarded; register 0 SHALL always read 0.
REQ-017 Read ports SHALL return regs[addr] combinationally with zero latency.
REQ-018 Bypass: when a commit is pending in the current cycle and read addr equals wb_write_reg, the port SHALL return wb_write_data in that same cycle (write-before-read).
REQ-019 Both read ports SHALL bypass independently; rs_addr=rt_addr SHALL give identical data on both ports.
REQ-020 wb_count SHALL increment by 1 on each commit, never on discarded writes, and wrap 0xFFFFFFFF -> 0x00000000.
REQ-021 Consecutive commits to the same register SHALL leave the last value; each SHALL count.
REQ-022 The MemtoReg bit SHALL have no effect when RegWrite=0.

Reset
REQ-023 rst=1 SHALL immediately clear all NREGS registers and wb_count to 0, independent of clk.
REQ-024 While rst=1 no commit SHALL occur and bypass SHALL be disabled; reads return 0.
REQ-025 An edge coinciding with rst deassertion SHALL NOT commit; the first commit is possible on the following edge.
REQ-026 Reset asserted mid-sequence SHALL discard all prior contents without partial retention.

Structure
REQ-027 A shared package SHALL hold the control bit indices (RegWrite=1, MemtoReg=0) and the DATA_W/ADDR_W defaults, reused by the MEM/WB register and the control unit.
REQ-028 The writeback select SHALL be a sub-module named wb_mux; storage, bypass and counter stay in wb_reg_file.
REQ-029 Storage SHALL be a flip-flop array, so that asynchronous reset is possible; no memory macro.

Verification
REQ-030 Reset: rst=1 with arbitrary inputs -> rs_data=rt_data=0 and wb_count=0; rst=0, control=2'b10, reg=3, alu=0x1234 -> regs[3]=0x1234 after one edge, wb_count=1.
REQ-031 Mux/bypass: control=2'b11, read_data=0xDEADBEEF, alu=0x5, reg=7, rs_addr=rt_addr=7 -> rs_data=rt_data=0xDEADBEEF before the edge; after the edge, regs[7]=0xDEADBEEF.
REQ-032 Zero register: control=2'b10, reg=0, alu=0xFFFF -> rs_addr=0 reads 0, no bypass, wb_count unchanged.
REQ-033 No-write: control=2'b01, reg=9, read_data=0xAA -> regs[9] unchanged, wb_count unchanged, wb_write_data=0xAA.
REQ-034 Wrap: force wb_count to 0xFFFFFFFF, one commit -> wb_count=0.
REQ-035 Reset mid-operation: commit 0x77 to r5, then assert rst between edges -> r5 reads 0 immediately; the edge at deassertion with a valid commit to r5 leaves r5=0.

Source files
------------

// File: rtl/wb_reg_file_pkg.sv
// Shared writeback definitions: control-bit positions and default widths used by
// MEM/WB, the control unit and the register file.
package wb_reg_file_pkg;

    localparam int unsigned DefaultDataW = 32;
    localparam int unsigned DefaultAddrW = 5;
    localparam int unsigned DefaultNregs = 32;

    // Writeback control word: {RegWrite, MemtoReg}
    localparam int unsigned CtrlW        = 2;
    localparam int unsigned CtrlRegWrite = 1;
    localparam int unsigned CtrlMemToReg = 0;

    localparam int unsigned CountW = 32;

endpackage

// File: rtl/wb_mux.sv
// Writeback value select: load data or ALU result.
module wb_mux
    import wb_reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = DefaultDataW
) (
    input  logic              mem_to_reg,
    input  logic [DATA_W-1:0] read_data,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] write_data
);

    always_comb begin
        write_data = mem_to_reg ? read_data : alu_result;
    end

endmodule

// File: rtl/wb_reg_file.sv
// Flip-flop register file with two bypassed read ports, writeback select and a
// committed-write counter; register 0 is hard zero.
module wb_reg_file
    import wb_reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = DefaultDataW,
    parameter int unsigned ADDR_W = DefaultAddrW,
    parameter int unsigned NREGS  = DefaultNregs
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CtrlW-1:0]  wb_control_in,
    input  logic [DATA_W-1:0] wb_read_data,
    input  logic [DATA_W-1:0] wb_alu_result,
    input  logic [ADDR_W-1:0] wb_write_reg,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_write_data,
    output logic [CountW-1:0] wb_count
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [CountW-1:0] wb_count_q;
    logic              reg_write;
    logic              mem_to_reg;
    logic              commit;

    assign reg_write  = wb_control_in[CtrlRegWrite];
    assign mem_to_reg = wb_control_in[CtrlMemToReg];

    // Gating with rst also disables the bypass while reset is held.
    assign commit = !rst && reg_write && (wb_write_reg != '0);

    wb_mux #(
        .DATA_W (DATA_W)
    ) u_wb_mux (
        .mem_to_reg (mem_to_reg),
        .read_data  (wb_read_data),
        .alu_result (wb_alu_result),
        .write_data (wb_write_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            regs_q[wb_write_reg] <= wb_write_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_count_q <= '0;
        end else if (commit) begin
            wb_count_q <= wb_count_q + 1'b1;
        end
    end

    // Write-before-read: a commit landing this cycle is visible on the read ports now.
    always_comb begin
        rs_data = regs_q[rs_addr];
        rt_data = regs_q[rt_addr];
        if (commit && (rs_addr == wb_write_reg)) begin
            rs_data = wb_write_data;
        end
        if (commit && (rt_addr == wb_write_reg)) begin
            rt_data = wb_write_data;
        end
    end

    assign wb_count = wb_count_q;

endmodule

// File: tb/tb_wb_reg_file.sv
// Self-checking bench for wb_reg_file: vector table through a scoreboard queue,
// then hand sequences for reset, counter wrap and reset mid-operation.
module tb_wb_reg_file;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  wb_control_in = '0;
    logic [31:0] wb_read_data = '0;
    logic [31:0] wb_alu_result = '0;
    logic [4:0]  wb_write_reg = '0;
    logic [4:0]  rs_addr = '0;
    logic [4:0]  rt_addr = '0;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] wb_write_data;
    logic [31:0] wb_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  ctrl;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
        logic [31:0] exp_count;
    } vec_t;

    typedef struct {
        logic [31:0] wdata;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] count;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];

    wb_reg_file dut (
        .clk           (clk),
        .rst           (rst),
        .wb_control_in (wb_control_in),
        .wb_read_data  (wb_read_data),
        .wb_alu_result (wb_alu_result),
        .wb_write_reg  (wb_write_reg),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .wb_write_data (wb_write_data),
        .wb_count      (wb_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] ctrl, input logic [31:0] rd, input logic [31:0] alu,
                         input logic [4:0] wreg, input logic [4:0] rs, input logic [4:0] rt);
        wb_control_in = ctrl;
        wb_read_data  = rd;
        wb_alu_result = alu;
        wb_write_reg  = wreg;
        rs_addr       = rs;
        rt_addr       = rt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        // ctrl, rd, alu, wreg, rs, rt, exp_wdata, exp_rs, exp_rt, exp_count (after edge)
        vecs[0]  = '{2'b10, 32'h0, 32'h1234, 5'd3, 5'd3, 5'd0, 32'h1234, 32'h1234, 32'h0, 32'd1};
        vecs[1]  = '{2'b00, 32'h0, 32'h0, 5'd0, 5'd3, 5'd3, 32'h0, 32'h1234, 32'h1234, 32'd1};
        vecs[2]  = '{2'b11, 32'hDEADBEEF, 32'h5, 5'd7, 5'd7, 5'd7,
                     32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'd2};
        vecs[3]  = '{2'b00, 32'h0, 32'h0, 5'd0, 5'd7, 5'd3, 32'h0, 32'hDEADBEEF, 32'h1234, 32'd2};
        vecs[4]  = '{2'b10, 32'h0, 32'hFFFF, 5'd0, 5'd0, 5'd0, 32'hFFFF, 32'h0, 32'h0, 32'd2};
        vecs[5]  = '{2'b01, 32'hAA, 32'h0, 5'd9, 5'd9, 5'd0, 32'hAA, 32'h0, 32'h0, 32'd2};
        vecs[6]  = '{2'b00, 32'h0, 32'h0, 5'd0, 5'd9, 5'd7, 32'h0, 32'h0, 32'hDEADBEEF, 32'd2};
        vecs[7]  = '{2'b10, 32'h0, 32'h11, 5'd12, 5'd12, 5'd3, 32'h11, 32'h11, 32'h1234, 32'd3};
        vecs[8]  = '{2'b10, 32'h0, 32'h22, 5'd12, 5'd3, 5'd12, 32'h22, 32'h1234, 32'h22, 32'd4};
        vecs[9]  = '{2'b00, 32'h0, 32'h0, 5'd0, 5'd12, 5'd31, 32'h0, 32'h22, 32'h0, 32'd4};
        vecs[10] = '{2'b11, 32'hCAFE, 32'h99, 5'd31, 5'd31, 5'd12, 32'hCAFE, 32'hCAFE, 32'h22, 32'd5};
        vecs[11] = '{2'b00, 32'h0, 32'h0, 5'd0, 5'd31, 5'd31, 32'h0, 32'hCAFE, 32'hCAFE, 32'd5};

        // Reset held with a commit-looking input pattern: nothing reads back, nothing counts
        drive(2'b11, 32'h1111_2222, 32'h3333_4444, 5'd4, 5'd4, 5'd4);
        #1;
        check("rst_rs", rs_data, 32'h0);
        check("rst_rt", rt_data, 32'h0);
        check("rst_count", wb_count, 32'h0);
        check("rst_wdata_mux", wb_write_data, 32'h1111_2222);
        @(posedge clk);
        #1;
        check("rst_edge_rs", rs_data, 32'h0);
        check("rst_edge_count", wb_count, 32'h0);
        @(negedge clk);
        drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd4, 5'd4);
        rst = 1'b0;
        #1;
        check("post_rst_r4", rs_data, 32'h0);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i].ctrl, vecs[i].rd, vecs[i].alu, vecs[i].wreg, vecs[i].rs, vecs[i].rt);
            sb.push_back('{vecs[i].exp_wdata, vecs[i].exp_rs, vecs[i].exp_rt, vecs[i].exp_count});
            #1;
            e = sb.pop_front();
            check($sformatf("vec%0d_wdata", i), wb_write_data, e.wdata);
            check($sformatf("vec%0d_rs", i), rs_data, e.rs);
            check($sformatf("vec%0d_rt", i), rt_data, e.rt);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_count", i), wb_count, e.count);
        end

        // Counter wrap
        @(negedge clk);
        drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        force dut.wb_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.wb_count_q;
        #1;
        check("wrap_preload", wb_count, 32'hFFFF_FFFF);
        drive(2'b10, 32'h0, 32'h1, 5'd2, 5'd2, 5'd0);
        @(posedge clk);
        #1;
        check("wrap_count", wb_count, 32'h0);
        drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd2, 5'd0);
        #1;
        check("wrap_r2", rs_data, 32'h1);

        // Reset mid-operation
        @(negedge clk);
        drive(2'b10, 32'h0, 32'h77, 5'd5, 5'd5, 5'd0);
        @(posedge clk);
        #1;
        drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd5, 5'd2);
        #1;
        check("mid_r5", rs_data, 32'h77);
        check("mid_count", wb_count, 32'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_r5", rs_data, 32'h0);
        check("mid_rst_r2", rt_data, 32'h0);
        check("mid_rst_count", wb_count, 32'h0);
        drive(2'b10, 32'h0, 32'h88, 5'd5, 5'd5, 5'd5);
        #1;
        check("mid_rst_nobypass", rs_data, 32'h0);
        // Deassert exactly at the edge: the edge still sees reset, so no commit
        @(posedge clk);
        rst <= 1'b0;
        #1;
        drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
        #1;
        check("deassert_edge_r5", rs_data, 32'h0);
        check("deassert_edge_count", wb_count, 32'h0);
        drive(2'b10, 32'h0, 32'h99, 5'd5, 5'd0, 5'd5);
        @(posedge clk);
        #1;
        drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
        #1;
        check("first_commit_r5", rs_data, 32'h99);
        check("first_commit_count", wb_count, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
